// File: rtl/apb_master.sv
// APB master: accepts one command at a time and runs it as a SETUP/ACCESS transfer.
// A transfer that waits too long is aborted and reported with rsp_err.
module apb_master #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [CNT_W-1:0]    wait_cnt_d;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                timeout_hit;

    // Ready in IDLE, or on the completing ACCESS edge so back-to-back commands skip IDLE.
    assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);

    // Counter never wraps, so a disabled timeout cannot fire spuriously.
    assign wait_cnt_d  = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q    <= SETUP;
                        psel_q     <= 1'b1;
                        penable_q  <= 1'b0;
                        pwrite_q   <= cmd_write;
                        paddr_q    <= cmd_addr;
                        pwdata_q   <= cmd_wdata;
                        wait_cnt_q <= '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        if (cmd_valid) begin
                            state_q    <= SETUP;
                            penable_q  <= 1'b0;
                            pwrite_q   <= cmd_write;
                            paddr_q    <= cmd_addr;
                            pwdata_q   <= cmd_wdata;
                            wait_cnt_q <= '0;
                        end else begin
                            state_q   <= IDLE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized transfers
// checked against a transfer-level model (wait count -> access length, error, data).
module tb_apb_master;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              pclk = 1'b0;
    logic              prst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready = 1'b0;
    logic [DATA_W-1:0] prdata = '0;

    int checks = 0;
    int errors = 0;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transfer-level model: the responder holds pready low for 'waits' ACCESS cycles.
    function automatic void model(input bit wr, input int waits, input logic [DATA_W-1:0] rd,
                                  output int acc, output bit err, output logic [DATA_W-1:0] data);
        err  = (TIMEOUT > 0) && (waits >= TIMEOUT);
        acc  = err ? TIMEOUT : waits + 1;
        data = (err || wr) ? '0 : rd;
    endfunction

    task automatic do_xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input int waits, input logic [DATA_W-1:0] rd, input string tag);
        int acc_exp;
        bit err_exp;
        logic [DATA_W-1:0] data_exp;
        int setup_cnt = 0;
        int access_cnt = 0;
        bit got = 0;
        model(wr, waits, rd, acc_exp, err_exp, data_exp);
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; pready = 1'b0;
        #1 chk({tag, ".ready_idle"}, cmd_ready, 1'b1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = $urandom;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (psel) begin
                chk({tag, ".paddr"}, paddr, a);
                chk({tag, ".pwrite"}, pwrite, wr);
                chk({tag, ".pwdata"}, pwdata, wd);
            end
            if (psel && !penable) begin
                setup_cnt++;
                pready = 1'b0;
                #1 chk({tag, ".ready_setup"}, cmd_ready, 1'b0);
            end else if (psel && penable) begin
                access_cnt++;
                pready = (access_cnt == waits + 1);
                prdata = pready ? rd : $urandom;
                #1 chk({tag, ".ready_access"}, cmd_ready, pready);
            end else begin
                pready = 1'b0;
            end
        end
        chk({tag, ".rsp_seen"}, got, 1'b1);
        chk({tag, ".setup_cycles"}, setup_cnt, 1);
        chk({tag, ".access_cycles"}, access_cnt, acc_exp);
        chk({tag, ".rsp_err"}, rsp_err, err_exp);
        chk({tag, ".rsp_rdata"}, rsp_rdata, data_exp);
        chk({tag, ".idle_psel"}, {psel, penable}, 2'b00);
        pready = 1'b0;
        @(negedge pclk);
        chk({tag, ".rsp_pulse_end"}, rsp_valid, 1'b0);
        $display("xfer %s: wr=%0d addr=0x%0h waits=%0d access=%0d err=%0d rdata=0x%0h",
                 tag, wr, a, waits, access_cnt, rsp_err, rsp_rdata);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_q[$];
        int rsp_cyc[$];
        int issued;
        int psel_cnt;
        int first_psel;
        int last_psel;
        bit acc;
        logic [ADDR_W-1:0] b2b_addr;

        // Reset state
        #2;
        chk("rst.psel", psel, 1'b0);
        chk("rst.penable", penable, 1'b0);
        chk("rst.pwrite", pwrite, 1'b0);
        chk("rst.paddr", paddr, '0);
        chk("rst.pwdata", pwdata, '0);
        chk("rst.rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        repeat (2) @(negedge pclk);
        prst = 1'b1;

        do_xfer(1'b1, 6'h05, 32'hDEADBEEF, 0, 32'h0, "zw_write");
        do_xfer(1'b0, 6'h2A, 32'h0BADF00D, 3, 32'h12345678, "rd_3wait");
        do_xfer(1'b0, 6'h13, 32'h55AA55AA, 10, 32'hCAFEF00D, "timeout");
        do_xfer(1'b0, 6'h14, 32'h11112222, 0, 32'hA5A5A5A5, "after_timeout");
        do_xfer(1'b1, 6'h20, 32'h76543210, 3, 32'hFFFFFFFF, "boundary_ok");
        do_xfer(1'b1, 6'h21, 32'h01020304, 4, 32'hFFFFFFFF, "boundary_to");

        // Back-to-back reads with a zero-wait responder
        @(negedge pclk);
        issued = 0; psel_cnt = 0; first_psel = -1; last_psel = -1;
        b2b_addr = 6'h08;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = b2b_addr; cmd_wdata = $urandom;
        pready = 1'b1; prdata = $urandom;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            acc = cmd_valid && cmd_ready;
            if (psel && penable) exp_q.push_back(prdata);
            @(posedge pclk);
            #1;
            if (acc) begin
                issued++;
                if (issued < 3) begin
                    b2b_addr = b2b_addr + 6'd1;
                    cmd_addr = b2b_addr;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            prdata = $urandom;
            @(negedge pclk);
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                chk("b2b.q_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("b2b.rdata", rsp_rdata, exp_q.pop_front());
                chk("b2b.err", rsp_err, 1'b0);
            end
            if (psel) begin
                psel_cnt++;
                if (first_psel < 0) first_psel = cyc;
                last_psel = cyc;
            end
        end
        pready = 1'b0;
        chk("b2b.issued", issued, 3);
        chk("b2b.rsp_count", rsp_cyc.size(), 3);
        chk("b2b.psel_cycles", psel_cnt, 6);
        chk("b2b.psel_contig", last_psel - first_psel + 1, 6);
        if (rsp_cyc.size() == 3) begin
            chk("b2b.gap1", rsp_cyc[1] - rsp_cyc[0], 2);
            chk("b2b.gap2", rsp_cyc[2] - rsp_cyc[1], 2);
        end
        $display("xfer b2b: issued=%0d rsp=%0d psel_cycles=%0d", issued, rsp_cyc.size(), psel_cnt);

        // Reset asserted mid-ACCESS
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h11; pready = 1'b0;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_mid.in_access", {psel, penable}, 2'b11);
        #2 prst = 1'b0;
        #1;
        chk("rst_mid.psel", psel, 1'b0);
        chk("rst_mid.penable", penable, 1'b0);
        chk("rst_mid.paddr", paddr, '0);
        chk("rst_mid.rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge pclk);
        prst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("rst_mid.no_rsp", {rsp_valid, psel}, 2'b00);
        end
        $display("xfer reset_mid_access: psel/penable dropped asynchronously");
        do_xfer(1'b0, 6'h3F, $urandom, 1, $urandom, "post_rst_read");

        // Randomized transfers
        for (int n = 0; n < 12; n++) begin
            do_xfer(1'($urandom), ADDR_W'($urandom), $urandom, int'($urandom_range(0, 6)),
                    $urandom, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 6, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum consecutive ACCESS cycles with pready low; 0 disables the timeout.
REQ-004 pclk  in  1  clock; all state changes on the rising edge.
REQ-005 prst  in  1  reset; asynchronous, active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_W  transfer address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-013 rsp_err  out  1  transfer ended by timeout; qualified by rsp_valid.
REQ-014 psel, penable, pwrite  out  1 each  APB control.
REQ-015 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-016 pready  in  1; prdata  in  DATA_W  APB responder handshake and read data.

Function
REQ-017 FSM states are IDLE, SETUP and ACCESS; all APB outputs and rsp_* outputs are registered.
REQ-018 Output encoding per state:
- IDLE: psel=0, penable=0.
- SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1.
REQ-019 cmd_ready is combinational: 1 in IDLE, 1 in ACCESS when pready=1, 0 otherwise.
REQ-020 On command acceptance:
- paddr, pwrite and pwdata load from cmd_* on the accepting edge.
- The FSM moves to SETUP on that edge.
REQ-021 SETUP moves to ACCESS unconditionally after exactly one cycle.
REQ-022 paddr, pwrite and pwdata hold stable from SETUP through the last ACCESS cycle.
REQ-023 pwdata is driven with cmd_wdata on reads as well; the responder ignores it.
REQ-024 In ACCESS, pready=0 holds state; pready=1 completes the transfer on that edge.
REQ-025 On completion:
- rsp_valid=1 and rsp_err=0 during the following cycle.
- rsp_rdata = prdata sampled on the completing edge for reads, 0 for writes.
REQ-026 Back-to-back transfers: if cmd_valid=1 on the completing edge, the next command is accepted and the FSM goes ACCESS->SETUP, giving a 2-cycle-per-transfer minimum.
REQ-027 Completion with no pending command: ACCESS->IDLE.
REQ-028 Wait counter behaviour:
- Counts consecutive ACCESS cycles with pready=0.
- Clears on entry to SETUP.
- Saturates; it never wraps.
REQ-029 Timeout (TIMEOUT>0), when pready is still 0 on the TIMEOUT-th consecutive wait edge:
- The transfer aborts and the FSM goes to IDLE.
- The next cycle has rsp_valid=1, rsp_err=1, rsp_rdata=0.
- cmd_ready stays 0 on the abort edge.
REQ-030 pready=1 on the same edge the timeout would fire counts as a normal completion (rsp_err=0).
REQ-031 rsp_valid is 1 for exactly one cycle per accepted command; there is no response backpressure.
REQ-032 Zero-wait latency: accept edge E0, SETUP after E0, ACCESS after E0+1, complete at E0+2, rsp_valid during the cycle after E0+2.

Reset
REQ-033 While prst=0 the block forces, immediately and asynchronously:
- FSM to IDLE and wait counter to 0.
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-034 Reset asserted mid-transfer drops psel and penable immediately; no response is ever produced for the aborted command.
REQ-035 The first command is accepted no earlier than the first rising edge after prst deasserts.

Verification
REQ-036 Zero-wait write: cmd addr=0x05, wdata=0xDEADBEEF, pready tied 1 -> psel 1 cycle with penable=0, then 1 cycle with penable=1; paddr=0x05, pwdata=0xDEADBEEF; rsp_valid=1 with rdata=0, err=0.
REQ-037 Read with 3 wait states: addr=0x2A, pready low for 3 ACCESS cycles then high with prdata=0x12345678 -> ACCESS lasts 4 cycles; rsp_rdata=0x12345678; paddr stable throughout.
REQ-038 Back-to-back: three commands held valid with zero-wait responder -> SETUP/ACCESS alternate with psel continuously 1; 3 rsp_valid pulses 2 cycles apart.
REQ-039 Timeout with TIMEOUT=4: pready held 0 -> exactly 4 ACCESS cycles, then IDLE; rsp_valid=1, rsp_err=1, rdata=0; the next command completes normally.
REQ-040 Reset mid-ACCESS: assert prst=0 between edges -> psel and penable fall without waiting for a clock edge; no rsp_valid; after release a new read at 0x3F completes correctly.
REQ-041 Boundary: pready=1 on the 4th wait edge with TIMEOUT=4 -> normal completion, err=0.
